fifo_rr_distributor: RTL and testbench

//  Reads words from the shared input FIFO and deals them round-robin, one word per channel, to NUM_CH

---
 rtl/fifo_rr_distributor.sv | 146 ++++++++++++++
 tb/tb_fifo_rr_distributor.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_distributor.sv
// fifo_rr_distributor
//  Reads words from a shared input FIFO and deals them round-robin, one word
//  per lane, to NUM_CH parallel filter lanes. One frame = NUM_CH words,
//  delivered to lanes 0..NUM_CH-1 in order.
//
// Ports
//  phy_clk_0   in   clock, rising edge
//  reset       in   asynchronous active-low reset
//  fifo_q      in   FIFO read data, valid RD_LAT cycles after fifo_rdreq
//  fifo_full   in   FIFO full flag
//  fifo_empty  in   FIFO empty flag
//  fifo_rdreq  out  FIFO read request (combinational)
//  ch_ready    in   per-lane ready, sampled only when a word is issued
//  flush       in   synchronous abort of the current frame
//  ch_data     out  broadcast data to all lanes, registered
//  ch_valid    out  one-hot lane write strobe, registered
//  cur_ch      out  next lane to be issued
//  busy        out  high while a frame is in progress
//  frame_done  out  one-cycle pulse once the last word of a frame is delivered
//  frame_cnt   out  completed frame count, wraps
module fifo_rr_distributor #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned CH_W       = 3,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned START_MODE = 0
) (
  input  logic              phy_clk_0,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0] ch_valid,
  output logic [CH_W-1:0]   cur_ch,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [RD_LAT-1:0] pipe_v;
  logic [CH_W-1:0]   pipe_ch [RD_LAT];

  logic start_c;
  logic ready_sel_c;
  logic issue_c;
  logic pipe_empty_c;

  // Frame start condition selected by mode
  assign start_c = (START_MODE == 0) ? fifo_full : ~fifo_empty;

  // Ready of the lane currently pointed at; mask form avoids an out-of-range index
  assign ready_sel_c = |(ch_ready & (NUM_CH'(1) << cur_ch));

  // A read is issued only from ISSUE, never on an empty FIFO, and never during flush
  assign issue_c    = (state == ISSUE) & ~fifo_empty & ready_sel_c & ~flush;
  assign fifo_rdreq = issue_c;

  assign pipe_empty_c = ~|pipe_v;

  // Control FSM, read-tracking pipeline and lane delivery
  always_ff @(posedge phy_clk_0 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cur_ch     <= '0;
      pipe_v     <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pipe_ch[i] <= '0;
      ch_valid   <= '0;
      ch_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      ch_valid   <= '0;

      // Each stage carries {valid, lane} of one outstanding read
      pipe_v[0]  <= issue_c;
      pipe_ch[0] <= cur_ch;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_ch[i] <= pipe_ch[i-1];
      end

      // The oldest stage lines up with fifo_q being valid this cycle
      if (pipe_v[RD_LAT-1] && !flush) begin
        ch_valid <= NUM_CH'(1) << pipe_ch[RD_LAT-1];
        ch_data  <= fifo_q;
      end

      if (flush) begin
        // Abort: discard outstanding reads without strobes, no frame credit
        pipe_v <= '0;
        state  <= IDLE;
        busy   <= 1'b0;
        cur_ch <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_c) begin
              state  <= ISSUE;
              busy   <= 1'b1;
              cur_ch <= '0;
            end
          end
          ISSUE: begin
            if (issue_c) begin
              if (cur_ch == LAST_CH) begin
                cur_ch <= '0;
                state  <= DRAIN;
              end else begin
                cur_ch <= cur_ch + CH_W'(1);
              end
            end
          end
          DRAIN: begin
            // Last delivery has already left the pipeline
            if (pipe_empty_c) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
              state      <= IDLE;
              busy       <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_distributor.sv
`timescale 1ns/1ps
module tb_fifo_rr_distributor;

  logic phy_clk_0 = 1'b0;
  always #5 phy_clk_0 = ~phy_clk_0;

  logic reset;
  logic flush;

  // Instance A: 8 lanes, 16-bit, RD_LAT=1, start on full
  logic [15:0] a_q;
  logic        a_full  = 1'b0;
  logic        a_empty = 1'b1;
  logic        a_rdreq;
  logic [7:0]  a_ready;
  logic [15:0] a_data;
  logic [7:0]  a_valid;
  logic [2:0]  a_cur;
  logic        a_busy, a_done;
  logic [15:0] a_cnt;

  // Instance B: 4 lanes, 12-bit, RD_LAT=3, start on not-empty
  logic [11:0] b_q;
  logic        b_full  = 1'b0;
  logic        b_empty = 1'b1;
  logic        b_rdreq;
  logic [3:0]  b_ready;
  logic [11:0] b_data;
  logic [3:0]  b_valid;
  logic [1:0]  b_cur;
  logic        b_busy, b_done;
  logic [15:0] b_cnt;

  fifo_rr_distributor #(.DATA_W(16), .NUM_CH(8), .CH_W(3), .RD_LAT(1), .START_MODE(0)) dut_a (
    .phy_clk_0(phy_clk_0), .reset(reset), .fifo_q(a_q), .fifo_full(a_full),
    .fifo_empty(a_empty), .fifo_rdreq(a_rdreq), .ch_ready(a_ready), .flush(flush),
    .ch_data(a_data), .ch_valid(a_valid), .cur_ch(a_cur), .busy(a_busy),
    .frame_done(a_done), .frame_cnt(a_cnt));

  fifo_rr_distributor #(.DATA_W(12), .NUM_CH(4), .CH_W(2), .RD_LAT(3), .START_MODE(1)) dut_b (
    .phy_clk_0(phy_clk_0), .reset(reset), .fifo_q(b_q), .fifo_full(b_full),
    .fifo_empty(b_empty), .fifo_rdreq(b_rdreq), .ch_ready(b_ready), .flush(flush),
    .ch_data(b_data), .ch_valid(b_valid), .cur_ch(b_cur), .busy(b_busy),
    .frame_done(b_done), .frame_cnt(b_cnt));

  typedef struct {
    logic [15:0] data;
    int          lane;
    int          due;
  } exp_t;

  typedef struct {
    logic [7:0] ready;
    logic       rdreq;
    logic [2:0] cur;
    logic       busy;
  } vec_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  logic [15:0] a_mem[$];
  logic [11:0] b_mem[$];
  vec_t tbl[11];

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int a_lane = 0;
  int b_lane = 0;
  int b_last_strobe = -1;

  logic        a_wr = 1'b0;
  logic [15:0] a_wd = '0;
  logic        b_wr = 1'b0;
  logic [11:0] b_wd = '0;
  logic [11:0] b_d1 = '0;
  logic [11:0] b_d2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge phy_clk_0) cyc <= cyc + 1;

  // FIFO model A (read latency 1) + scoreboard push on each issued read
  always @(posedge phy_clk_0) begin : fifo_a
    logic [15:0] w;
    w = 16'hDEAD;
    if (a_rdreq) begin
      chk("A read only when non-empty", 32'(a_mem.size() != 0), 32'd1);
      if (a_mem.size() != 0) begin
        w = a_mem.pop_front();
        sb_a.push_back('{data: w, lane: a_lane, due: cyc + 2});
        a_lane = (a_lane + 1) % 8;
      end
    end
    if (!reset || flush) begin
      sb_a.delete();
      a_lane = 0;
    end
    if (a_wr) a_mem.push_back(a_wd);
    a_q     <= w;
    a_empty <= (a_mem.size() == 0);
    a_full  <= (a_mem.size() >= 8);
  end

  // FIFO model B (read latency 3)
  always @(posedge phy_clk_0) begin : fifo_b
    logic [11:0] w;
    w = 12'hBAD;
    if (b_rdreq) begin
      chk("B read only when non-empty", 32'(b_mem.size() != 0), 32'd1);
      if (b_mem.size() != 0) begin
        w = b_mem.pop_front();
        sb_b.push_back('{data: 16'(w), lane: b_lane, due: cyc + 4});
        b_lane = (b_lane + 1) % 4;
      end
    end
    if (!reset || flush) begin
      sb_b.delete();
      b_lane = 0;
    end
    if (b_wr) b_mem.push_back(b_wd);
    b_d1    <= w;
    b_d2    <= b_d1;
    b_q     <= b_d2;
    b_empty <= (b_mem.size() == 0);
    b_full  <= (b_mem.size() >= 4);
  end

  // Delivery monitor: pop expected words when due, compare strobe and data
  always @(negedge phy_clk_0) begin : mon
    logic [7:0]  ea;
    logic [15:0] da;
    logic [3:0]  eb;
    logic [11:0] db;
    ea = '0; da = '0; eb = '0; db = '0;
    if (sb_a.size() != 0 && sb_a[0].due == cyc) begin
      ea = 8'(1) << sb_a[0].lane;
      da = sb_a[0].data;
      void'(sb_a.pop_front());
    end
    if (ea != 0 || a_valid != 0) begin
      chk("A ch_valid", 32'(a_valid), 32'(ea));
      if (ea != 0) chk("A ch_data", 32'(a_data), 32'(da));
    end
    if (sb_b.size() != 0 && sb_b[0].due == cyc) begin
      eb = 4'(1) << sb_b[0].lane;
      db = 12'(sb_b[0].data);
      void'(sb_b.pop_front());
    end
    if (eb != 0 || b_valid != 0) begin
      chk("B ch_valid", 32'(b_valid), 32'(eb));
      if (eb != 0) chk("B ch_data", 32'(b_data), 32'(db));
    end
    if (b_valid != 0) b_last_strobe = cyc;
  end

  task automatic a_write(input logic [15:0] d);
    a_wd = d; a_wr = 1'b1;
    @(negedge phy_clk_0);
    a_wr = 1'b0;
  endtask

  task automatic b_write(input logic [11:0] d);
    b_wd = d; b_wr = 1'b1;
    @(negedge phy_clk_0);
    b_wr = 1'b0;
  endtask

  task automatic a_wait_cur(input logic [2:0] ch, input string name);
    for (int i = 0; i < 40; i++) begin
      if (a_busy && a_cur == ch) break;
      @(negedge phy_clk_0);
    end
    chk(name, 32'({a_busy, a_cur}), 32'({1'b1, ch}));
  endtask

  task automatic a_wait_done(input string name, output int maxrun);
    int run;
    run = 0; maxrun = 0;
    for (int i = 0; i < 60; i++) begin
      if (a_done) break;
      run = a_rdreq ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      @(negedge phy_clk_0);
    end
    chk(name, 32'(a_done), 32'd1);
  endtask

  task automatic b_wait_done(input string name, output int done_cyc);
    for (int i = 0; i < 60; i++) begin
      if (b_done) break;
      @(negedge phy_clk_0);
    end
    done_cyc = cyc;
    chk(name, 32'(b_done), 32'd1);
  endtask

  task automatic a_check_reset(input string tag);
    chk({tag, " ch_valid"},   32'(a_valid), 32'd0);
    chk({tag, " ch_data"},    32'(a_data),  32'd0);
    chk({tag, " cur_ch"},     32'(a_cur),   32'd0);
    chk({tag, " busy"},       32'(a_busy),  32'd0);
    chk({tag, " frame_done"}, 32'(a_done),  32'd0);
    chk({tag, " frame_cnt"},  32'(a_cnt),   32'd0);
    chk({tag, " fifo_rdreq"}, 32'(a_rdreq), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int maxrun;
    int done_cyc;
    int seen;

    // Backpressure table: lane 3 stalls 5 cycles, then the frame completes
    for (int i = 0; i < 5; i++) tbl[i] = '{ready: 8'hF7, rdreq: 1'b0, cur: 3'd3, busy: 1'b1};
    for (int i = 5; i < 10; i++) tbl[i] = '{ready: 8'hFF, rdreq: 1'b1, cur: 3'(i - 2), busy: 1'b1};
    tbl[10] = '{ready: 8'hFF, rdreq: 1'b0, cur: 3'd0, busy: 1'b1};

    reset = 1'b0; flush = 1'b0;
    a_ready = 8'hFF; b_ready = 4'hF;
    repeat (2) @(negedge phy_clk_0);
    a_check_reset("reset");
    chk("reset B frame_cnt", 32'(b_cnt), 32'd0);
    reset = 1'b1;
    @(negedge phy_clk_0);

    // Full-triggered frame, all lanes ready
    for (int i = 1; i <= 8; i++) a_write(16'(i));
    a_wait_done("T1 frame_done", maxrun);
    chk("T1 consecutive rdreq", 32'(maxrun), 32'd8);
    chk("T1 frame_cnt", 32'(a_cnt), 32'd1);
    chk("T1 busy at done", 32'(a_busy), 32'd0);
    @(negedge phy_clk_0);
    chk("T1 frame_done one cycle", 32'(a_done), 32'd0);

    // Lane 3 not ready mid-frame
    a_ready = 8'hF7;
    for (int i = 0; i < 8; i++) a_write(16'h0010 + 16'(i));
    a_wait_cur(3'd3, "T3 reach lane 3");
    for (int i = 0; i < 11; i++) begin
      a_ready = tbl[i].ready;
      #1;
      chk($sformatf("T3 rdreq step %0d", i), 32'(a_rdreq), 32'(tbl[i].rdreq));
      chk($sformatf("T3 cur_ch step %0d", i), 32'(a_cur), 32'(tbl[i].cur));
      chk($sformatf("T3 busy step %0d", i), 32'(a_busy), 32'(tbl[i].busy));
      @(negedge phy_clk_0);
    end
    a_wait_done("T3 frame_done", maxrun);
    chk("T3 frame_cnt", 32'(a_cnt), 32'd2);

    // Flush after five issues
    for (int i = 0; i < 8; i++) a_write(16'h0020 + 16'(i));
    a_wait_cur(3'd5, "T5 reach lane 5");
    flush = 1'b1;
    #1;
    chk("T5 rdreq blocked by flush", 32'(a_rdreq), 32'd0);
    @(negedge phy_clk_0);
    flush = 1'b0;
    chk("T5 busy after flush", 32'(a_busy), 32'd0);
    chk("T5 cur_ch after flush", 32'(a_cur), 32'd0);
    chk("T5 no strobe after flush", 32'(a_valid), 32'd0);
    seen = 0;
    repeat (4) begin
      if (a_done || a_valid != 0) seen++;
      @(negedge phy_clk_0);
    end
    chk("T5 no done or strobe while idle", 32'(seen), 32'd0);
    chk("T5 frame_cnt unchanged", 32'(a_cnt), 32'd2);
    for (int i = 0; i < 5; i++) a_write(16'h0028 + 16'(i));
    a_wait_done("T5 next frame done", maxrun);
    chk("T5 frame_cnt", 32'(a_cnt), 32'd3);

    // Not-empty start, long latency, single word then stall on empty
    b_write(12'hA5A);
    repeat (4) @(negedge phy_clk_0);
    chk("T2 stall cur_ch", 32'(b_cur), 32'd1);
    chk("T2 stall busy", 32'(b_busy), 32'd1);
    chk("T2 stall rdreq", 32'(b_rdreq), 32'd0);
    b_write(12'h111);
    b_write(12'h222);
    b_write(12'h333);
    b_wait_done("T4 frame_done", done_cyc);
    chk("T4 done after last strobe", 32'(done_cyc > b_last_strobe), 32'd1);
    chk("T4 frame_cnt", 32'(b_cnt), 32'd1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 8; i++) a_write(16'h0030 + 16'(i));
    a_wait_cur(3'd4, "T6 reach lane 4");
    #2 reset = 1'b0;
    #1;
    a_check_reset("T6 async reset");
    chk("T6 B frame_cnt reset", 32'(b_cnt), 32'd0);
    @(negedge phy_clk_0);
    reset = 1'b1;
    @(negedge phy_clk_0);

    // Frame counter wrap
    force dut_a.frame_cnt = 16'hFFFF;
    @(negedge phy_clk_0);
    release dut_a.frame_cnt;
    for (int i = 0; i < 4; i++) a_write(16'h0038 + 16'(i));
    a_wait_done("T6 wrap frame_done", maxrun);
    chk("T6 frame_cnt wraps", 32'(a_cnt), 32'd0);
    repeat (3) @(negedge phy_clk_0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
